// File: rtl/keypad_emulator_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
package keypad_pkg;
  localparam int KP_ROWS  = 4;
  localparam int KP_COLS  = 4;
  localparam int KP_KEY_W = 4;

  localparam logic [7:0] KP_LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } kp_emu_state_t;

  function automatic logic [1:0] kp_key_row(input logic [KP_KEY_W-1:0] key);
    return key[3:2];
  endfunction

  function automatic logic [1:0] kp_key_col(input logic [KP_KEY_W-1:0] key);
    return key[1:0];
  endfunction
endpackage

// File: rtl/keypad_emulator_if.sv
// Press-request handshake between a requester (master) and the keypad emulator (slave).
interface keypad_emulator_if #(
  parameter int CNT_W = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_key;
  logic [CNT_W-1:0] req_hold;

  modport master (output req_valid, output req_key, output req_hold, input  req_ready);
  modport slave  (input  req_valid, input  req_key, input  req_hold, output req_ready);
endinterface

// File: rtl/keypad_emu_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying contact-bounce noise.
module keypad_emu_lfsr
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic lfsr_bit
);
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= KP_LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_bit = lfsr_q[0];
endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: holds one key for a requested time and mirrors column drive onto its row.
// Optional contact bounce around each press is enabled with `define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int BOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_emulator_if.slave   req,
  input  logic [KP_COLS-1:0] cols,
  output logic [KP_ROWS-1:0] rows,
  output logic               key_down,
  output logic               busy,
  output logic               done
);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end
  if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
    $error("BOUNCE_CYCLES must be at least 1");
  end

  kp_emu_state_t         state_q, state_d;
  logic [KP_KEY_W-1:0]   key_q, key_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  key_down_q, key_down_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [KP_ROWS-1:0]    rows_q, rows_d;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_LD = CNT_W'(BOUNCE_CYCLES);
  logic lfsr_bit;

  keypad_emu_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .lfsr_bit (lfsr_bit)
  );
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    key_down_d = key_down_q;
    done_d     = 1'b0;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid && ready_q) begin
          key_d      = req.req_key;
          hold_cnt_d = (req.req_hold == '0) ? CNT_W'(1) : req.req_hold;
          ready_d    = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d    = BOUNCE_IN;
          gap_cnt_d  = BNC_LD;
          key_down_d = lfsr_bit;
`else
          state_d    = HOLD;
          key_down_d = 1'b1;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      // Bounce windows reuse gap_cnt, which is otherwise idle while the contact moves.
      BOUNCE_IN: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d    = HOLD;
          gap_cnt_d  = '0;
          key_down_d = 1'b1;
        end else begin
          gap_cnt_d  = gap_cnt_q - CNT_W'(1);
          key_down_d = lfsr_bit;
        end
      end
      BOUNCE_OUT: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d    = GAP;
          gap_cnt_d  = GAP_LD;
          key_down_d = 1'b0;
        end else begin
          gap_cnt_d  = gap_cnt_q - CNT_W'(1);
          key_down_d = lfsr_bit;
        end
      end
`endif
      HOLD: begin
        if (hold_cnt_q == CNT_W'(1)) begin
          hold_cnt_d = '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d    = BOUNCE_OUT;
          gap_cnt_d  = BNC_LD;
          key_down_d = lfsr_bit;
`else
          state_d    = GAP;
          gap_cnt_d  = GAP_LD;
          key_down_d = 1'b0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
          done_d    = 1'b1;
          ready_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        key_down_d = 1'b0;
        ready_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Row follows the current contact state and live column drive, one cycle later.
    rows_d = '0;
    for (int r = 0; r < KP_ROWS; r++) begin
      rows_d[r] = key_down_q && (2'(r) == kp_key_row(key_q)) && cols[kp_key_col(key_q)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      key_down_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      rows_q     <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      key_down_q <= key_down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      rows_q     <= rows_d;
    end
  end

  assign req.req_ready = ready_q;
  assign rows          = rows_q;
  assign key_down      = key_down_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: each press queues its expected contact profile, a monitor checks it at done.
module tb_keypad_emulator;
  localparam int CNT_W = 16;

  typedef struct {
    int         kd;    // key_down high cycles
    int         rc;    // rows non-zero cycles
    logic [3:0] ro;    // OR of all rows seen
    int         gap;   // key_down low cycles between fall and done
    int         lat;   // cycles from accept edge to done cycle, inclusive
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_down, busy, done;

  keypad_emulator_if #(.CNT_W(CNT_W)) rif ();

  keypad_emulator #(.CNT_W(CNT_W), .GAP_CYCLES(8), .BOUNCE_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rif),
    .cols     (cols),
    .rows     (rows),
    .key_down (key_down),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   pushed   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accumulates the contact profile and compares it against the queue head at each done.
  int   kd_cnt = 0, rc = 0, gap = 0, lat = 0;
  logic [3:0] ro = '0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      kd_cnt = 0; rc = 0; gap = 0; lat = 0; ro = '0;
    end else begin
      lat++;
      if (key_down) kd_cnt++;
      else if (kd_cnt > 0 && !done) gap++;
      if (rows != 4'b0000) rc++;
      ro = ro | rows;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("key_down_cycles", kd_cnt, e.kd);
          chk("rows_cycles", rc, e.rc);
          chk("rows_or", int'(ro), int'(e.ro));
          chk("gap_cycles", gap, e.gap);
          chk("accept_to_done", lat, e.lat);
          done_cnt++;
        end
        kd_cnt = 0; rc = 0; gap = 0; ro = '0;
      end
      if (rif.req_valid && rif.req_ready) lat = 0;
    end
  end

  task automatic push(input int kd, input int rcn, input logic [3:0] ron, input int g, input int l);
    exp_t x;
    x.kd = kd; x.rc = rcn; x.ro = ron; x.gap = g; x.lat = l;
    sbq.push_back(x);
    pushed++;
  endtask

  // Returns #1 after the edge at which the pending request was accepted.
  task automatic wait_acc(output int t);
    int  n;
    bit  r;
    n = 0;
    do begin
      r = rif.req_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic send(input logic [3:0] key, input logic [CNT_W-1:0] hold);
    int t;
    rif.req_key   = key;
    rif.req_hold  = hold;
    rif.req_valid = 1'b1;
    wait_acc(t);
    rif.req_valid = 1'b0;
    rif.req_key   = 4'h0;
    rif.req_hold  = CNT_W'(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !rif.req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
  endtask

  int acc1, acc2;

  initial begin
    rst_n         = 1'b0;
    cols          = 4'b1111;
    rif.req_valid = 1'b0;
    rif.req_key   = 4'h0;
    rif.req_hold  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rows", int'(rows), 0);
    chk("reset_ready", int'(rif.req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_key_down", int'(key_down), 0);
    chk("reset_done", int'(done), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cols = 4'b0000;

    // Key 6 (row1,col2), hold 5, scanner cycling one-hot from the first contact cycle.
    push(5, 1, 4'b0010, 8, 14);
    send(4'd6, CNT_W'(5));
    for (int i = 0; i < 12; i++) begin
      cols = 4'(1 << (i % 4));
      @(posedge clk); #1;
    end
    cols = 4'b0000;
    wait_idle();

    // Zero hold is one cycle; key 15 on column 3.
    cols = 4'b1000;
    push(1, 1, 4'b1000, 8, 10);
    send(4'd15, CNT_W'(0));
    wait_idle();

    // Multi-column drive on key 0, then its own column removed.
    cols = 4'b0011;
    push(6, 3, 4'b0001, 8, 15);
    send(4'd0, CNT_W'(6));
    repeat (3) begin
      @(posedge clk); #1;
    end
    cols = 4'b0010;
    wait_idle();
    cols = 4'b0000;

    // Two requests presented back to back with valid held high.
    push(3, 0, 4'b0000, 8, 12);
    push(2, 0, 4'b0000, 8, 11);
    rif.req_key   = 4'd9;
    rif.req_hold  = CNT_W'(3);
    rif.req_valid = 1'b1;
    wait_acc(acc1);
    rif.req_key   = 4'd6;
    rif.req_hold  = CNT_W'(2);
    wait_acc(acc2);
    rif.req_valid = 1'b0;
    chk("b2b_spacing", acc2 - acc1, 12);
    wait_idle();

    // Reset mid-hold: rows drop at once, no done, next request behaves normally.
    cols = 4'b0001;
    send(4'd0, CNT_W'(20));
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("hold_rows_before_reset", int'(rows), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rows", int'(rows), 0);
    chk("async_reset_key_down", int'(key_down), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_ready", int'(rif.req_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    cols = 4'b1000;
    push(2, 2, 4'b1000, 8, 11);
    send(4'd15, CNT_W'(2));
    wait_idle();
    cols = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
